// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word width, watchdog length and receiver FSM states.
// Also used by the transmitter so both ends agree on the word width.
package i2s_pkg;

  localparam int unsigned I2S_WIDTH   = 16;
  localparam int unsigned I2S_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    UNLOCKED,
    SYNCING,
    RUN
  } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with a rising-edge strobe
// derived from the synchronized level.
module i2s_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign q    = chain_q[SYNC_STAGES-1];
  assign rise = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCK/WS/SD in clk_sys and emits framed stereo PCM pairs.
// Optional I2S_RX_MONO_MIX_EN adds a mono_chan output holding (left + right) >>> 1.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = I2S_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = I2S_TIMEOUT
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan,
  output logic             sample_valid,
  output logic             locked
`ifdef I2S_RX_MONO_MIX_EN
  ,
  output logic [WIDTH-1:0] mono_chan
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] BITS_FULL = CW'(WIDTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH - 1) {1'b0}}};

  logic sclk_s, lrclk_s, sdata_s;
  logic bck_rise;
  logic lr_rise_unused, sd_rise_unused, sclk_q_unused;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (sclk),
    .q       (sclk_s),
    .rise    (bck_rise)
  );

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (lrclk),
    .q       (lrclk_s),
    .rise    (lr_rise_unused)
  );

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (sdata),
    .q       (sdata_s),
    .rise    (sd_rise_unused)
  );

  assign sclk_q_unused = sclk_s;

  i2s_state_e       state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    bitcnt_q;
  logic [TW-1:0]    tcnt_q;
  logic             lr_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_valid_q;

  logic [WIDTH-1:0] word;
  logic             lr_edge;
  logic             expire;

  // Shifting by bitcnt >= WIDTH yields zero, so surplus bits fall away naturally.
  assign word    = sr_q | ({WIDTH{sdata_s}} & (MSB_ONE >> bitcnt_q));
  assign lr_edge = bck_rise && (lrclk_s != lr_q);
  assign expire  = !bck_rise && (tcnt_q == TLAST);

`ifdef I2S_RX_MONO_MIX_EN
  logic signed [WIDTH:0] mix_sum;
  assign mix_sum = $signed({hold_q[WIDTH-1], hold_q}) + $signed({word[WIDTH-1], word});
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      tcnt_q       <= '0;
      lr_q         <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
      mono_chan    <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (bck_rise) begin
        tcnt_q <= '0;
      end else if (tcnt_q != TLAST) begin
        tcnt_q <= tcnt_q + TW'(1);
      end

      if (expire) begin
        state_q      <= UNLOCKED;
        sr_q         <= '0;
        bitcnt_q     <= '0;
        hold_valid_q <= 1'b0;
        left_chan    <= '0;
        right_chan   <= '0;
        locked       <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
        mono_chan    <= '0;
`endif
      end else if (bck_rise) begin
        if (lr_edge) begin
          // This rise still carries the old word's LSB; word already includes it.
          lr_q     <= lrclk_s;
          sr_q     <= '0;
          bitcnt_q <= '0;
          case (state_q)
            UNLOCKED: state_q <= SYNCING;
            SYNCING: begin
              if (!lr_q) begin
                hold_q       <= word;
                hold_valid_q <= 1'b1;
              end else if (hold_valid_q) begin
                left_chan    <= hold_q;
                right_chan   <= word;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                state_q      <= RUN;
`ifdef I2S_RX_MONO_MIX_EN
                mono_chan    <= WIDTH'(mix_sum >>> 1);
`endif
              end
            end
            RUN: begin
              if (!lr_q) begin
                hold_q <= word;
              end else begin
                left_chan    <= hold_q;
                right_chan   <= word;
                sample_valid <= 1'b1;
`ifdef I2S_RX_MONO_MIX_EN
                mono_chan    <= WIDTH'(mix_sum >>> 1);
`endif
              end
            end
            default: state_q <= UNLOCKED;
          endcase
        end else begin
          sr_q <= word;
          if (bitcnt_q != BITS_FULL) begin
            bitcnt_q <= bitcnt_q + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives an I2S stream at BCK = clk_sys/8 and
// scoreboards every expected stereo pair against sample_valid.
module tb_i2s_rx;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMO   = 1024;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic             sclk    = 1'b1;
  logic             lrclk   = 1'b0;
  logic             sdata   = 1'b0;
  logic [WIDTH-1:0] left_chan, right_chan;
  logic             sample_valid, locked;
`ifdef I2S_RX_MONO_MIX_EN
  logic [WIDTH-1:0] mono_chan;
`endif

  i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .locked       (locked)
`ifdef I2S_RX_MONO_MIX_EN
    ,
    .mono_chan    (mono_chan)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_rise = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard: every sample_valid must match the next queued pair and its cycle.
  always @(negedge clk_sys) begin
    if (sample_valid === 1'b1) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_width: sample_valid high on consecutive cycles at cyc=%0d", cyc);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got L=%h R=%h at cyc=%0d, none expected",
                 left_chan, right_chan, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (left_chan !== e.l || right_chan !== e.r || cyc !== e.cyc) begin
          bad++;
          $display("FAIL pair: got L=%h R=%h cyc=%0d, want L=%h R=%h cyc=%0d",
                   left_chan, right_chan, cyc, e.l, e.r, e.cyc);
        end
      end
    end
    prev_valid = (sample_valid === 1'b1);
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic l, input logic d, input logic push,
                          input logic [WIDTH-1:0] el, input logic [WIDTH-1:0] er);
    sclk  = 1'b0;
    lrclk = l;
    sdata = d;
    repeat (4) @(posedge clk_sys);
    #1;
    sclk      = 1'b1;
    last_rise = cyc;
    if (push) exp_q.push_back('{l: el, r: er, cyc: cyc + int'(SYNC) + 1});
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  // LSB goes out with the next word's lrclk, as standard I2S does.
  task automatic send_word(input logic lr_this, input logic lr_next, input logic [31:0] data,
                           input int n, input logic push,
                           input logic [WIDTH-1:0] el, input logic [WIDTH-1:0] er);
    for (int i = n - 1; i >= 1; i--) send_bit(lr_this, data[i], 1'b0, '0, '0);
    send_bit(lr_next, data[0], push, el, er);
  endtask

  task automatic check_lock(input string name, input logic want);
    @(negedge clk_sys);
    total++;
    if (locked !== want) begin
      bad++;
      $display("FAIL %s: locked=%b want %b", name, locked, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    total += 4;
    if (left_chan !== '0) begin bad++; $display("FAIL rst_left: got %h want 0", left_chan); end
    if (right_chan !== '0) begin bad++; $display("FAIL rst_right: got %h want 0", right_chan); end
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    send_word(1'b0, 1'b1, 32'h1111, 16, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'h2222, 16, 1'b0, '0, '0);
    send_word(1'b0, 1'b1, 32'h8001, 16, 1'b0, '0, '0);
    check_lock("basic_prelock", 1'b0);
    send_word(1'b1, 1'b0, 32'h7FFE, 16, 1'b1, 16'h8001, 16'h7FFE);
    check_lock("basic_locked", 1'b1);
    total++;
    if (left_chan !== 16'h8001 || right_chan !== 16'h7FFE) begin
      bad++;
      $display("FAIL basic_hold: got L=%h R=%h want 8001 7FFE", left_chan, right_chan);
    end
  endtask

  task automatic test_long_words;
    send_word(1'b0, 1'b1, 32'hABCDEF, 24, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'h123456, 24, 1'b1, 16'hABCD, 16'h1234);
  endtask

  task automatic test_short_words;
    send_word(1'b0, 1'b1, 32'hFFF, 12, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'h001, 12, 1'b1, 16'hFFF0, 16'h0010);
  endtask

`ifdef I2S_RX_MONO_MIX_EN
  task automatic test_mono;
    send_word(1'b0, 1'b1, 32'h7FFF, 16, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'h7FFF, 16, 1'b1, 16'h7FFF, 16'h7FFF);
    @(negedge clk_sys);
    total++;
    if (mono_chan !== 16'h7FFF) begin bad++; $display("FAIL mono_pos: got %h want 7fff", mono_chan); end
    send_word(1'b0, 1'b1, 32'h8000, 16, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'h7FFF, 16, 1'b1, 16'h8000, 16'h7FFF);
    @(negedge clk_sys);
    total++;
    if (mono_chan !== 16'hFFFF) begin bad++; $display("FAIL mono_neg: got %h want ffff", mono_chan); end
  endtask
`endif

  task automatic test_timeout;
    int start;
    start = last_rise;
    while (cyc < start + int'(TMO) - 10) @(negedge clk_sys);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL tmo_early: locked=%b want 1", locked); end
    while (cyc < start + int'(TMO) + 16) @(negedge clk_sys);
    total += 3;
    if (locked !== 1'b0) begin bad++; $display("FAIL tmo_unlock: locked=%b want 0", locked); end
    if (left_chan !== '0) begin bad++; $display("FAIL tmo_left: got %h want 0", left_chan); end
    if (right_chan !== '0) begin bad++; $display("FAIL tmo_right: got %h want 0", right_chan); end
`ifdef I2S_RX_MONO_MIX_EN
    total++;
    if (mono_chan !== '0) begin bad++; $display("FAIL tmo_mono: got %h want 0", mono_chan); end
`endif
    @(posedge clk_sys);
    #1;
    send_word(1'b0, 1'b1, 32'h0F0F, 16, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'hF0F0, 16, 1'b0, '0, '0);
    check_lock("tmo_first_pair", 1'b0);
    @(posedge clk_sys);
    #1;
    send_word(1'b0, 1'b1, 32'h4321, 16, 1'b0, '0, '0);
    send_word(1'b1, 1'b0, 32'hBEEF, 16, 1'b1, 16'h4321, 16'hBEEF);
    check_lock("tmo_relock", 1'b1);
  endtask

  task automatic test_reset_mid_word;
    logic [15:0] rw;
    @(posedge clk_sys);
    #1;
    rw = 16'hC3C3;
    send_word(1'b0, 1'b1, 32'h5A5A, 16, 1'b0, '0, '0);
    for (int i = 15; i >= 9; i--) send_bit(1'b1, rw[i], 1'b0, '0, '0);
    sclk  = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    total += 3;
    if (left_chan !== '0) begin bad++; $display("FAIL mid_left: got %h want 0", left_chan); end
    if (right_chan !== '0) begin bad++; $display("FAIL mid_right: got %h want 0", right_chan); end
    if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked: got %b want 0", locked); end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    for (int i = 8; i >= 1; i--) send_bit(1'b1, rw[i], 1'b0, '0, '0);
    send_bit(1'b0, rw[0], 1'b0, '0, '0);
    send_word(1'b0, 1'b1, 32'h1357, 16, 1'b0, '0, '0);
    check_lock("mid_prelock", 1'b0);
    send_word(1'b1, 1'b0, 32'h2468, 16, 1'b1, 16'h1357, 16'h2468);
    check_lock("mid_relock", 1'b1);
  endtask

  initial begin
    test_reset();
    @(posedge clk_sys);
    #1;
    test_basic();
    test_long_words();
    test_short_words();
`ifdef I2S_RX_MONO_MIX_EN
    test_mono();
`endif
    test_timeout();
    test_reset_mid_word();
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_valid: %0d expected pairs never arrived, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
